bht_branch_predictor: RTL and testbench
=======================================

Name: bht_branch_predictor

Overview:
- Dynamic branch direction predictor; consumes the resolved branch outcome produced by the branch comparator.
- Holds a branch history table (BHT) of 2-bit saturating counters, indexed by PC bits.
- Predicts direction for the fetch stage with 1-cycle registered latency.
- Trains on resolved outcomes and flags mispredictions so the PC-redirect logic can flush.

Parameters:
- WIDTH, 32, PC width in bits.
- ENTRIES, 64, number of BHT entries; power of 2, min 2.
- IDX_BITS, $clog2(ENTRIES), index width; derived, not overridden.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- pred_req  input  1  fetch requests a prediction this cycle.
- pred_pc  input  WIDTH  PC of the branch being predicted.
- pred_valid  output  1  prediction valid; registered, asserted the cycle after pred_req.
- pred_taken  output  1  predicted direction; meaningful only when pred_valid=1.
- upd_valid  input  1  resolved branch outcome present this cycle.
- upd_pc  input  WIDTH  PC of the resolved branch.
- upd_taken  input  1  actual outcome (comparator branch_taken).
- upd_pred  input  1  direction that was predicted for this branch.
- mispredict  output  1  registered 1-cycle pulse, the cycle after upd_valid, when upd_taken != upd_pred.

Behaviour:
- Index = pc[IDX_BITS+1:2]. Bits [1:0] and bits above the index are ignored, so aliasing is allowed.
- Counter encoding:
  - 00 = strong-not-taken
  - 01 = weak-not-taken
  - 10 = weak-taken
  - 11 = strong-taken
  - Prediction = counter[1].
- Reset (rst=1 at a clock edge):
  - All BHT entries become 01.
  - pred_valid=0, pred_taken=0, mispredict=0.
  - Any pred_req or upd_valid presented in the same cycle is dropped.
- Predict path:
  - On a cycle with pred_req=1, next cycle: pred_valid=1 and pred_taken = BHT[idx(pred_pc)][1].
  - On a cycle with pred_req=0, next cycle: pred_valid=0 and pred_taken=0.
  - Back-to-back requests are accepted every cycle.
- Update path, on upd_valid=1:
  - If upd_taken=1: counter increments, saturating at 11.
  - If upd_taken=0: counter decrements, saturating at 00.
  - The write takes effect at the clock edge.
- mispredict:
  - Next cycle, mispredict = upd_valid & (upd_taken ^ upd_pred).
  - Otherwise mispredict=0.
- Same cycle, same index (predict and update): read-before-write. The prediction reflects the counter value before the update; the update is never lost.
- Same cycle, different indices: both proceed independently.
- Only one update per cycle. No internal FSM beyond the table and output registers; no backpressure.

Optional Feature:
- Macro: BHT_STATS_EN.
- When defined, adds two outputs:
  - stat_branches (32): counts upd_valid cycles.
  - stat_mispredicts (32): counts mispredict events, incremented in the same cycle mispredict is raised.
- Both counters clear on rst and saturate at 0xFFFFFFFF; no wrap.
- When undefined, these ports and counters do not exist and all other behaviour is identical.

Test Plan:
1. Reset, then pred_req=1 with pred_pc=0x0000_0040 -> next cycle pred_valid=1, pred_taken=0 (counter 01).
2. Three updates at upd_pc=0x40 with upd_taken=1, upd_pred=0, then predict 0x40 -> pred_taken=1; counter is 11. Further taken updates keep it at 11. One not-taken update still gives pred_taken=1 (counter 10).
3. Saturation low: from reset, two not-taken updates at 0x80 -> counter 00. Then one taken update -> counter 01, pred_taken=0.
4. Same-cycle collision: counter at 01 for 0x40. pred_req and upd_valid (taken) at 0x40 in the same cycle -> pred_taken=0 (old value). Next prediction gives 1.
5. Aliasing and mispredict: train 0x100 taken twice -> 0x200 (same index 0) predicts taken. upd_taken=0 with upd_pred=1 -> mispredict=1 for exactly one cycle. upd_taken=upd_pred -> mispredict=0.
6. Reset mid-operation: assert rst together with upd_valid and pred_req -> next cycle all outputs 0, all entries 01. With BHT_STATS_EN defined, both stat counters read 0.

Source files
------------

// File: rtl/bht_branch_predictor.sv
// Branch history table of 2-bit saturating counters: registered prediction,
// resolved-outcome training and mispredict pulse. Optional counters: BHT_STATS_EN.
module bht_branch_predictor #(
  parameter  int WIDTH    = 32,
  parameter  int ENTRIES  = 64,
  localparam int IDX_BITS = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_req,
  input  logic [WIDTH-1:0] pred_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic             upd_taken,
  input  logic             upd_pred,
  output logic             mispredict
`ifdef BHT_STATS_EN
  ,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts
`endif
);

  logic [1:0]          bht [ENTRIES];
  logic [IDX_BITS-1:0] pred_idx;
  logic [IDX_BITS-1:0] upd_idx;
  logic [1:0]          upd_cur;
  logic [1:0]          upd_next;
  logic                upd_wrong;
  logic                unused_pc;

  assign pred_idx  = pred_pc[IDX_BITS+1:2];
  assign upd_idx   = upd_pc[IDX_BITS+1:2];
  assign upd_wrong = upd_valid & (upd_taken ^ upd_pred);
  // Word-offset and high PC bits do not select an entry; aliasing is intended.
  assign unused_pc = ^{pred_pc, upd_pc};

  always_comb begin
    upd_cur  = bht[upd_idx];
    upd_next = upd_cur;
    if (upd_taken) begin
      if (upd_cur != 2'b11) upd_next = upd_cur + 2'd1;
    end else begin
      if (upd_cur != 2'b00) upd_next = upd_cur - 2'd1;
    end
  end

  // The prediction samples the table before this edge's write lands, which
  // gives read-before-write on a same-index collision without a bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      pred_valid <= pred_req;
      pred_taken <= pred_req & bht[pred_idx][1];
      mispredict <= upd_wrong;
      if (upd_valid) bht[upd_idx] <= upd_next;
    end
  end

`ifdef BHT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd_valid && stat_branches != '1) stat_branches <= stat_branches + 32'd1;
      if (upd_wrong && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bht_branch_predictor.sv
// Directed and randomized bench for bht_branch_predictor against a per-entry
// integer counter model; also checks the optional statistics when BHT_STATS_EN is set.
module tb_bht_branch_predictor;
  localparam int WIDTH   = 32;
  localparam int ENTRIES = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             pred_req;
  logic [WIDTH-1:0] pred_pc;
  logic             pred_valid;
  logic             pred_taken;
  logic             upd_valid;
  logic [WIDTH-1:0] upd_pc;
  logic             upd_taken;
  logic             upd_pred;
  logic             mispredict;
`ifdef BHT_STATS_EN
  logic [31:0]      stat_branches;
  logic [31:0]      stat_mispredicts;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cnt [ENTRIES];
  logic [31:0] m_branches = '0;
  logic [31:0] m_misps    = '0;

  always #5 clk = ~clk;

  bht_branch_predictor #(.WIDTH(WIDTH), .ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst),
    .pred_req(pred_req), .pred_pc(pred_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_pred(upd_pred),
    .mispredict(mispredict)
`ifdef BHT_STATS_EN
    ,
    .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Predicts outputs from the current inputs and model, advances one clock,
  // then compares just after the edge.
  task automatic tick();
    bit e_pv, e_pt, e_mp;
    int pi, ui;
    pi = idx_of(pred_pc);
    ui = idx_of(upd_pc);
    if (rst) begin
      e_pv = 0; e_pt = 0; e_mp = 0;
      for (int i = 0; i < ENTRIES; i++) cnt[i] = 1;
      m_branches = '0;
      m_misps    = '0;
    end else begin
      e_pv = pred_req;
      e_pt = pred_req && (cnt[pi] >= 2);
      e_mp = upd_valid && (upd_taken != upd_pred);
      if (upd_valid) begin
        if (upd_taken) cnt[ui] = (cnt[ui] < 3) ? cnt[ui] + 1 : 3;
        else           cnt[ui] = (cnt[ui] > 0) ? cnt[ui] - 1 : 0;
        if (m_branches != 32'hFFFF_FFFF) m_branches = m_branches + 1;
        if (e_mp && m_misps != 32'hFFFF_FFFF) m_misps = m_misps + 1;
      end
    end
    @(posedge clk);
    #1;
    check("pred_valid", {31'b0, pred_valid}, {31'b0, e_pv});
    check("pred_taken", {31'b0, pred_taken}, {31'b0, e_pt});
    check("mispredict", {31'b0, mispredict}, {31'b0, e_mp});
`ifdef BHT_STATS_EN
    check("stat_branches", stat_branches, m_branches);
    check("stat_mispredicts", stat_mispredicts, m_misps);
`endif
  endtask

  task automatic idle();
    pred_req = 0; pred_pc = '0;
    upd_valid = 0; upd_pc = '0; upd_taken = 0; upd_pred = 0;
  endtask

  task automatic predict(logic [31:0] pc);
    idle();
    pred_req = 1; pred_pc = pc;
    tick();
    idle();
  endtask

  task automatic update(logic [31:0] pc, bit taken, bit pred);
    idle();
    upd_valid = 1; upd_pc = pc; upd_taken = taken; upd_pred = pred;
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    tick();

    // Fresh entry is weak-not-taken.
    predict(32'h0000_0040);
    check("t1_valid", {31'b0, pred_valid}, 32'd1);
    check("t1_taken", {31'b0, pred_taken}, 32'd0);

    // Train up to strong-taken, saturate, then step back to weak-taken.
    for (int i = 0; i < 3; i++) update(32'h40, 1, 0);
    predict(32'h40);
    check("t2_taken_after_train", {31'b0, pred_taken}, 32'd1);
    for (int i = 0; i < 2; i++) update(32'h40, 1, 1);
    update(32'h40, 0, 1);
    predict(32'h40);
    check("t2_weak_taken", {31'b0, pred_taken}, 32'd1);
    update(32'h40, 0, 1);
    predict(32'h40);
    check("t2_back_to_weak_nt", {31'b0, pred_taken}, 32'd0);

    // Low saturation.
    update(32'h80, 0, 0);
    update(32'h80, 0, 0);
    update(32'h80, 0, 0);
    update(32'h80, 1, 0);
    predict(32'h80);
    check("t3_low_sat", {31'b0, pred_taken}, 32'd0);
    update(32'h80, 1, 0);
    predict(32'h80);
    check("t3_recovered", {31'b0, pred_taken}, 32'd1);

    // Same-cycle, same-index collision: old value predicted, update kept.
    idle();
    pred_req = 1; pred_pc = 32'h40;
    upd_valid = 1; upd_pc = 32'h40; upd_taken = 1; upd_pred = 0;
    tick();
    check("t4_collide_old", {31'b0, pred_taken}, 32'd0);
    idle();
    predict(32'h40);
    check("t4_collide_new", {31'b0, pred_taken}, 32'd1);

    // Aliasing through index 0 and mispredict pulse width.
    update(32'h100, 1, 0);
    update(32'h100, 1, 1);
    predict(32'h200);
    check("t5_alias", {31'b0, pred_taken}, 32'd1);
    update(32'h200, 0, 1);
    check("t5_misp_pulse", {31'b0, mispredict}, 32'd1);
    tick();
    check("t5_misp_cleared", {31'b0, mispredict}, 32'd0);
    update(32'h200, 1, 1);
    check("t5_no_misp", {31'b0, mispredict}, 32'd0);

    // Reset with traffic in flight, then sweep every entry back-to-back.
    idle();
    pred_req = 1; pred_pc = 32'h40;
    upd_valid = 1; upd_pc = 32'h40; upd_taken = 0; upd_pred = 1;
    rst = 1;
    tick();
    rst = 0;
    check("t6_rst_valid", {31'b0, pred_valid}, 32'd0);
    check("t6_rst_misp", {31'b0, mispredict}, 32'd0);
`ifdef BHT_STATS_EN
    check("t6_rst_branches", stat_branches, 32'd0);
    check("t6_rst_misps", stat_mispredicts, 32'd0);
`endif
    idle();
    for (int i = 0; i < ENTRIES; i++) begin
      pred_req = 1;
      pred_pc  = 32'(i) << 2;
      tick();
      check("t6_entry_weak_nt", {31'b0, pred_taken}, 32'd0);
    end
    idle();
    tick();

    // Randomized traffic concentrated on few indices to force collisions.
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      pred_req  = ($urandom_range(0, 3) != 0);
      upd_valid = ($urandom_range(0, 2) != 0);
      upd_taken = 1'($urandom);
      upd_pred  = 1'($urandom);
      pred_pc   = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
      upd_pc    = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 9) == 0) pred_pc = upd_pc;
      tick();
    end
    rst = 0;
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
